// File: rtl/mem_bus_pkg.sv
// Shared constants for the memory bus arbiter: FSM encodings, RW and grant codes.
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic GRANT_F = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETUP   = 3'd1;
    localparam state_t ST_STROBE  = 3'd2;
    localparam state_t ST_RELEASE = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/mfc_sync.sv
// Two-flop synchronizer bringing the memory's MFC handshake into the clk domain.
module mfc_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin sharing of the EN/RW/MFC memory handshake between fetch (F) and data (D).
//   state   | meaning
//   IDLE    | arbitrate pending requests, latch the winner's bus values
//   SETUP   | address/RW/data settle on the bus, EN low
//   STROBE  | EN high, wait for synchronized MFC or timeout
//   RELEASE | EN low, wait for MFC to drop or timeout
//   DONE    | one-cycle ack (and err) to the granted requester
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] MAR_to_MEM,
    output logic [DATA_W-1:0] MDR_to_MEM,
    output logic              EN,
    output logic              RW,
    input  logic [DATA_W-1:0] MEM_to_MDR,
    input  logic              MFC
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic              r_grant;
    logic              r_last;
    logic              r_tmo;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_en;
    logic              r_rw;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_f_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_f_ack;
    logic              r_d_ack;
    logic              r_err;

    logic w_mfc_s;
    logic w_cnt_last;
    logic w_pick_d;

    mfc_sync u_mfc_sync (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (MFC),
        .o_q   (w_mfc_s)
    );

    assign w_cnt_last = (r_cnt == TMO_LAST);
    // D wins when alone, or on contention when F was served last
    assign w_pick_d   = d_req && (!f_req || (r_last == GRANT_F));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= GRANT_F;
            r_last    <= GRANT_D;
            r_tmo     <= 1'b0;
            r_cnt     <= '0;
            r_en      <= 1'b0;
            r_rw      <= 1'b0;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_f_rdata <= '0;
            r_d_rdata <= '0;
            r_f_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_f_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (f_req || d_req) begin
                        r_grant <= w_pick_d ? GRANT_D : GRANT_F;
                        r_last  <= w_pick_d ? GRANT_D : GRANT_F;
                        r_mar   <= w_pick_d ? d_addr : f_addr;
                        r_rw    <= w_pick_d ? d_rw : RW_READ;
                        if (w_pick_d) begin
                            r_mdr <= d_wdata;
                        end
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_en    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (w_mfc_s) begin
                        if (r_rw == RW_READ) begin
                            if (r_grant == GRANT_D) r_d_rdata <= MEM_to_MDR;
                            else                    r_f_rdata <= MEM_to_MDR;
                        end
                        r_en    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_RELEASE;
                    end else if (w_cnt_last) begin
                        r_tmo   <= 1'b1;
                        r_en    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!w_mfc_s || w_cnt_last) begin
                        // MFC still high here means the release itself timed out
                        r_f_ack <= (r_grant == GRANT_F);
                        r_d_ack <= (r_grant == GRANT_D);
                        r_err   <= r_tmo | w_mfc_s;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_tmo   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign f_ack      = r_f_ack;
    assign d_ack      = r_d_ack;
    assign err        = r_err;
    assign f_rdata    = r_f_rdata;
    assign d_rdata    = r_d_rdata;
    assign busy       = (r_state != ST_IDLE);
    assign MAR_to_MEM = r_mar;
    assign MDR_to_MEM = r_mdr;
    assign EN         = r_en;
    assign RW         = r_rw;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural EN/MFC memory model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        f_ack;
    logic [15:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_rw = 1'b1;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        err;
    logic        busy;
    logic [15:0] MAR_to_MEM;
    logic [15:0] MDR_to_MEM;
    logic        EN;
    logic        RW;
    logic [15:0] MEM_to_MDR;
    logic        MFC;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_ack      (f_ack),
        .f_rdata    (f_rdata),
        .d_req      (d_req),
        .d_rw       (d_rw),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .err        (err),
        .busy       (busy),
        .MAR_to_MEM (MAR_to_MEM),
        .MDR_to_MEM (MDR_to_MEM),
        .EN         (EN),
        .RW         (RW),
        .MEM_to_MDR (MEM_to_MDR),
        .MFC        (MFC)
    );

    always #5 clk = ~clk;

    // memory: MFC 5 ns after EN rises, cleared 3 ns after EN falls
    logic [15:0] mem [0:255];
    bit          no_mfc = 1'b0;

    initial begin
        MFC = 1'b0;
        MEM_to_MDR = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h02] = 16'h1043;
        mem[8'h04] = 16'h7777;
        mem[8'h30] = 16'h5555;
        forever begin
            @(EN);
            if (EN === 1'b1) begin
                #5;
                if (EN === 1'b1 && !no_mfc) begin
                    if (RW) MEM_to_MDR = mem[MAR_to_MEM[7:0]];
                    else    mem[MAR_to_MEM[7:0]] = MDR_to_MEM;
                    MFC = 1'b1;
                end
            end else begin
                #3;
                MFC = 1'b0;
            end
        end
    end

    // bus monitor, sampled on the falling edge
    logic        prev_en = 1'b0;
    logic        prev_rw = 1'b0;
    logic [15:0] prev_mar = '0;
    logic [15:0] prev_mdr = '0;
    int          since_bus = 0;
    int          rise_delay = 0;
    int          en_hi_run = 0;
    int          en_lo_run = 0;
    int          last_hi = 0;
    int          gap_at_rise = 0;
    int          rise_cnt = 0;
    int          bus_unstable = 0;
    int          overlap = 0;
    logic [15:0] strobe_mar = '0;
    logic [15:0] strobe_mdr = '0;
    logic        strobe_rw = 1'b0;
    bit          ack_q [$];

    always @(negedge clk) begin
        bit chg;
        chg = (MAR_to_MEM !== prev_mar) || (RW !== prev_rw) || (MDR_to_MEM !== prev_mdr);
        if (chg) since_bus = 0;
        else     since_bus++;
        if (EN) begin
            if (!prev_en) begin
                rise_delay  = since_bus;
                gap_at_rise = en_lo_run;
                en_hi_run   = 0;
                rise_cnt++;
                strobe_mar  = MAR_to_MEM;
                strobe_rw   = RW;
                strobe_mdr  = MDR_to_MEM;
            end else if (chg) begin
                bus_unstable++;
            end
            en_hi_run++;
        end else begin
            if (prev_en) begin
                last_hi   = en_hi_run;
                en_lo_run = 0;
            end
            en_lo_run++;
        end
        if (f_ack && d_ack) overlap++;
        if (f_ack) ack_q.push_back(1'b0);
        if (d_ack) ack_q.push_back(1'b1);
        prev_en  = EN;
        prev_rw  = RW;
        prev_mar = MAR_to_MEM;
        prev_mdr = MDR_to_MEM;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // raise one request and wait (bounded) for its ack; request dropped on the ack cycle
    task automatic run_access(input bit is_d, input string tag, output logic got_err);
        bit seen = 1'b0;
        got_err = 1'b0;
        @(negedge clk);
        if (is_d) d_req = 1'b1;
        else      f_req = 1'b1;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if ((is_d && d_ack) || (!is_d && f_ack)) begin
                seen    = 1'b1;
                got_err = err;
                if (is_d) d_req = 1'b0;
                else      f_req = 1'b0;
            end
        end
        check_eq({tag, "_ack_seen"}, {31'd0, seen}, 32'd1);
        d_req = 1'b0;
        f_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int   q0;
        int   r0;
        int   acks;
        bit   hit;

        do_reset();
        @(negedge clk);
        check_eq("rst_en", {31'd0, EN}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_acks", {30'd0, f_ack, d_ack}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_rw", {31'd0, RW}, 32'd0);
        check_eq("rst_mar", {16'd0, MAR_to_MEM}, 32'd0);
        check_eq("rst_mdr", {16'd0, MDR_to_MEM}, 32'd0);
        check_eq("rst_rdata", {f_rdata, d_rdata}, 32'd0);

        // 1: fetch read
        q0 = ack_q.size();
        f_addr = 16'h0002;
        run_access(1'b0, "t1", e);
        check_eq("t1_err", {31'd0, e}, 32'd0);
        check_eq("t1_rdata", {16'd0, f_rdata}, 32'h1043);
        check_eq("t1_strobe_mar", {16'd0, strobe_mar}, 32'h0002);
        check_eq("t1_strobe_rw", {31'd0, strobe_rw}, 32'd1);
        check_eq("t1_en_after_setup", rise_delay, 32'd1);
        repeat (4) @(negedge clk);
        check_eq("t1_ack_count", ack_q.size() - q0, 32'd1);

        // 2: data write then read-back
        d_rw = 1'b0; d_addr = 16'h0020; d_wdata = 16'hBEEF;
        run_access(1'b1, "t2w", e);
        check_eq("t2_wr_rw", {31'd0, strobe_rw}, 32'd0);
        check_eq("t2_wr_mdr", {16'd0, strobe_mdr}, 32'hBEEF);
        check_eq("t2_wr_err", {31'd0, e}, 32'd0);
        d_rw = 1'b1; d_wdata = 16'h0000;
        run_access(1'b1, "t2r", e);
        check_eq("t2_rd_data", {16'd0, d_rdata}, 32'hBEEF);
        check_eq("t2_f_rdata_kept", {16'd0, f_rdata}, 32'h1043);

        // 4: MFC never arrives
        no_mfc = 1'b1;
        d_rw = 1'b1; d_addr = 16'h0030;
        run_access(1'b1, "t4", e);
        check_eq("t4_err", {31'd0, e}, 32'd1);
        check_eq("t4_en_high_len", last_hi, 32'd16);
        check_eq("t4_rdata_kept", {16'd0, d_rdata}, 32'hBEEF);
        no_mfc = 1'b0;
        @(negedge clk);
        check_eq("t4_err_cleared", {31'd0, err}, 32'd0);

        // 3: simultaneous requests after reset
        do_reset();
        q0 = ack_q.size();
        f_addr = 16'h0002; d_rw = 1'b1; d_addr = 16'h0004;
        f_req = 1'b1; d_req = 1'b1;
        acks = 0;
        for (int c = 0; c < 400 && acks < 4; c++) begin
            @(negedge clk);
            if (f_ack || d_ack) acks++;
            if (acks == 4) begin
                f_req = 1'b0; d_req = 1'b0;
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        check_eq("t3_ack_total", acks, 32'd4);
        if (ack_q.size() >= q0 + 4) begin
            check_eq("t3_order0", {31'd0, ack_q[q0]}, 32'd0);
            check_eq("t3_order1", {31'd0, ack_q[q0+1]}, 32'd1);
            check_eq("t3_order2", {31'd0, ack_q[q0+2]}, 32'd0);
            check_eq("t3_order3", {31'd0, ack_q[q0+3]}, 32'd1);
        end
        check_eq("t3_overlap", overlap, 32'd0);
        check_eq("t3_f_rdata", {16'd0, f_rdata}, 32'h1043);
        check_eq("t3_d_rdata", {16'd0, d_rdata}, 32'h7777);

        // 5: reset while strobing
        repeat (3) @(negedge clk);
        q0 = ack_q.size();
        f_addr = 16'h0004;
        f_req = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            hit = EN;
        end
        check_eq("t5_en_seen", {31'd0, hit}, 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_async_en", {31'd0, EN}, 32'd0);
        check_eq("t5_async_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_async_acks", {30'd0, f_ack, d_ack}, 32'd0);
        f_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t5_no_ack", ack_q.size() - q0, 32'd0);
        f_addr = 16'h0002;
        run_access(1'b0, "t5", e);
        check_eq("t5_err", {31'd0, e}, 32'd0);
        check_eq("t5_rdata", {16'd0, f_rdata}, 32'h1043);

        // 6: back-to-back data reads with d_req held through the first ack
        repeat (2) @(negedge clk);
        r0 = rise_cnt;
        d_rw = 1'b1; d_addr = 16'h0020;
        d_req = 1'b1;
        acks = 0;
        for (int c = 0; c < 200 && acks < 2; c++) begin
            @(negedge clk);
            if (d_ack) acks++;
            if (acks == 2) d_req = 1'b0;
        end
        d_req = 1'b0;
        check_eq("t6_acks", acks, 32'd2);
        check_eq("t6_strobes", rise_cnt - r0, 32'd2);
        // 3 RELEASE + DONE + IDLE + SETUP with this memory's MFC timing
        check_eq("t6_en_gap", gap_at_rise, 32'd6);
        check_eq("t6_rdata", {16'd0, d_rdata}, 32'hBEEF);
        check_eq("bus_stable_under_en", bus_unstable, 32'd0);
        check_eq("acks_never_overlap", overlap, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
